// File: rtl/ccd_pkg.sv
// Shared constants, FSM state type and configuration clamp helpers for the
// TCD1209D line scheduler and driver.
package ccd_pkg;

    localparam int LINE_WIDTH = 2088;
    localparam int F_CNT_MIN  = 2102;
    localparam int F_CNT_MAX  = 6250000;
    localparam int F1_MIN     = 2;
    localparam int F1_MAX     = 16;
    localparam int F1_RST     = 16;
    localparam int F_CNT_RST  = 6250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FRAME = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  f1;
        logic [22:0] f_cnt;
        logic [15:0] lines;
    } cfg_t;

    // Divider must be even: drop the LSB before saturating.
    function automatic logic [7:0] clamp_f1(input logic [7:0] v);
        logic [7:0] e;
        e = {v[7:1], 1'b0};
        if (e < 8'(F1_MIN)) return 8'(F1_MIN);
        if (e > 8'(F1_MAX)) return 8'(F1_MAX);
        return e;
    endfunction

    function automatic logic [22:0] clamp_f_cnt(input logic [22:0] v);
        if (v < 23'(F_CNT_MIN)) return 23'(F_CNT_MIN);
        if (v > 23'(F_CNT_MAX)) return 23'(F_CNT_MAX);
        return v;
    endfunction

    function automatic logic [15:0] clamp_lines(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/ccd_line_scheduler_if.sv
// Host configuration, driver handshake and capture framing signals of the
// line scheduler, bundled with host/driver (master) and scheduler (slave) views.
interface ccd_line_scheduler_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_f1_freq;
    logic [22:0] cfg_f_cnt;
    logic [15:0] cfg_lines;
    logic        run;
    logic        os_tvalid;
    logic [7:0]  f1_freq;
    logic [22:0] f_cnt;
    logic        cfg_applied;
    logic        cfg_clamped;
    logic        line_start;
    logic        line_end;
    logic        frame_start;
    logic        frame_end;
    logic [15:0] line_idx;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        tvalid_gated;

    modport master (
        output cfg_valid, cfg_f1_freq, cfg_f_cnt, cfg_lines, run, os_tvalid,
        input  cfg_ready, f1_freq, f_cnt, cfg_applied, cfg_clamped,
               line_start, line_end, frame_start, frame_end,
               line_idx, frame_cnt, busy, tvalid_gated
    );

    modport slave (
        input  cfg_valid, cfg_f1_freq, cfg_f_cnt, cfg_lines, run, os_tvalid,
        output cfg_ready, f1_freq, f_cnt, cfg_applied, cfg_clamped,
               line_start, line_end, frame_start, frame_end,
               line_idx, frame_cnt, busy, tvalid_gated
    );
endinterface

// File: rtl/ccd_edge_sync.sv
// Two-flop synchroniser with registered rise/fall pulses; one cycle of extra
// latency on the edges keeps downstream logic fed from flops only.
module ccd_edge_sync (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        rise_d = s1_q & ~s2_q;
        fall_d = ~s1_q & s2_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync = s2_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ccd_line_scheduler.sv
// Frame/line scheduler for the TCD1209D driver: clamps host configuration,
// commits it at safe line boundaries and frames driver lines for capture.
module ccd_line_scheduler
    import ccd_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    ccd_line_scheduler_if.slave   bus
);

    logic os_sync, os_rise, os_fall;

    ccd_edge_sync u_os_sync (
        .clk  (sys_clk),
        .srst (sys_rst),
        .din  (bus.os_tvalid),
        .sync (os_sync),
        .rise (os_rise),
        .fall (os_fall)
    );

    state_e      state_q, state_d;
    cfg_t        pend_q, pend_d;
    logic        pending_q, pending_d;
    logic [7:0]  f1_q, f1_d;
    logic [22:0] f_cnt_q, f_cnt_d;
    logic [15:0] lines_act_q, lines_act_d;
    logic        applied_q, applied_d;
    logic        clamped_q, clamped_d;
    logic        line_start_q, line_start_d;
    logic        line_end_q, line_end_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic [15:0] line_idx_q, line_idx_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;
    logic        in_frame_q, in_frame_d;

    logic        accept;
    logic        last_line;
    logic        frame_done;
    logic        commit;
    cfg_t        req_clamped;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        pending_d     = pending_q;
        f1_d          = f1_q;
        f_cnt_d       = f_cnt_q;
        lines_act_d   = lines_act_q;
        applied_d     = 1'b0;
        clamped_d     = clamped_q;
        line_start_d  = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_idx_d    = line_idx_q;
        frame_cnt_d   = frame_cnt_q;
        in_frame_d    = in_frame_q;
        frame_done    = 1'b0;

        accept            = bus.cfg_valid & ~pending_q;
        last_line         = (line_idx_q == lines_act_q - 16'd1);
        req_clamped.f1    = clamp_f1(bus.cfg_f1_freq);
        req_clamped.f_cnt = clamp_f_cnt(bus.cfg_f_cnt);
        req_clamped.lines = clamp_lines(bus.cfg_lines);

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Only a fresh rise starts a frame, so a line already in
                // progress when arming is skipped.
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (os_rise) begin
                    state_d       = ST_FRAME;
                    frame_start_d = 1'b1;
                    line_start_d  = 1'b1;
                    line_idx_d    = 16'd0;
                    in_frame_d    = 1'b1;
                end
            end
            ST_FRAME: begin
                if (os_rise) begin
                    line_start_d = 1'b1;
                    line_idx_d   = line_idx_q + 16'd1;
                    in_frame_d   = 1'b1;
                end
                if (os_fall) begin
                    line_end_d = 1'b1;
                    in_frame_d = 1'b0;
                    if (last_line) begin
                        frame_done  = 1'b1;
                        frame_end_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = bus.run ? ST_ARM : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Driver settings only change between lines and never inside a frame.
        commit = os_fall & pending_q & ((state_q != ST_FRAME) | frame_done);
        if (commit) begin
            f1_d        = pend_q.f1;
            f_cnt_d     = pend_q.f_cnt;
            lines_act_d = pend_q.lines;
            applied_d   = 1'b1;
            pending_d   = 1'b0;
        end else if (accept) begin
            pend_d    = req_clamped;
            pending_d = 1'b1;
            clamped_d = (req_clamped.f1    != bus.cfg_f1_freq) |
                        (req_clamped.f_cnt != bus.cfg_f_cnt)   |
                        (req_clamped.lines != bus.cfg_lines);
        end

        busy_d = (state_d == ST_FRAME);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            pending_q     <= 1'b0;
            f1_q          <= 8'(F1_RST);
            f_cnt_q       <= 23'(F_CNT_RST);
            lines_act_q   <= 16'd1;
            applied_q     <= 1'b0;
            clamped_q     <= 1'b0;
            line_start_q  <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_idx_q    <= 16'd0;
            frame_cnt_q   <= 16'd0;
            busy_q        <= 1'b0;
            in_frame_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pending_q     <= pending_d;
            f1_q          <= f1_d;
            f_cnt_q       <= f_cnt_d;
            lines_act_q   <= lines_act_d;
            applied_q     <= applied_d;
            clamped_q     <= clamped_d;
            line_start_q  <= line_start_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_idx_q    <= line_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            busy_q        <= busy_d;
            in_frame_q    <= in_frame_d;
        end
    end

    assign bus.cfg_ready    = ~pending_q;
    assign bus.f1_freq      = f1_q;
    assign bus.f_cnt        = f_cnt_q;
    assign bus.cfg_applied  = applied_q;
    assign bus.cfg_clamped  = clamped_q;
    assign bus.line_start   = line_start_q;
    assign bus.line_end     = line_end_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_end    = frame_end_q;
    assign bus.line_idx     = line_idx_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.busy         = busy_q;
    assign bus.tvalid_gated = os_sync & in_frame_q;

endmodule

// File: tb/tb_ccd_line_scheduler.sv
// Directed bench for ccd_line_scheduler: a simple os_tvalid line generator,
// a negedge event monitor and one task per scenario.
module tb_ccd_line_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccd_line_scheduler_if bus ();

    ccd_line_scheduler dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int fs_n = 0, ls_n = 0, le_n = 0, fe_n = 0, ap_n = 0, ap_fe_n = 0;
    int last_fe_le = 0;
    logic [15:0] idx_log[$];

    always @(negedge clk) begin
        if (bus.frame_start) fs_n++;
        if (bus.line_start) begin
            ls_n++;
            idx_log.push_back(bus.line_idx);
        end
        if (bus.line_end) le_n++;
        if (bus.frame_end) begin
            fe_n++;
            last_fe_le = le_n;
        end
        if (bus.cfg_applied) begin
            ap_n++;
            if (bus.frame_end) ap_fe_n++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_line(input int h, input int l);
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (h) @(negedge clk);
        bus.os_tvalid = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_cfg(input logic [7:0] f1, input logic [22:0] fc, input logic [15:0] ln);
        @(negedge clk);
        bus.cfg_f1_freq = f1;
        bus.cfg_f_cnt   = fc;
        bus.cfg_lines   = ln;
        bus.cfg_valid   = 1'b1;
        @(negedge clk);
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.f1_freq !== 8'd16) begin n_bad++; $display("FAIL reset_f1: got %0d want 16", bus.f1_freq); end
        n_cmp++; if (bus.f_cnt !== 23'd6250) begin n_bad++; $display("FAIL reset_f_cnt: got %0d want 6250", bus.f_cnt); end
        n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cfg_ready); end
        n_cmp++; if ({bus.line_start, bus.line_end, bus.frame_start, bus.frame_end, bus.cfg_applied} !== 5'b0)
            begin n_bad++; $display("FAIL reset_pulses: got %b want 00000",
                {bus.line_start, bus.line_end, bus.frame_start, bus.frame_end, bus.cfg_applied}); end
        n_cmp++; if ({bus.busy, bus.tvalid_gated, bus.cfg_clamped} !== 3'b0)
            begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.tvalid_gated, bus.cfg_clamped}); end
        n_cmp++; if (bus.line_idx !== 16'd0 || bus.frame_cnt !== 16'd0)
            begin n_bad++; $display("FAIL reset_counts: got idx=%0d cnt=%0d want 0/0", bus.line_idx, bus.frame_cnt); end
        $display("reset: f1=%0d f_cnt=%0d ready=%b", bus.f1_freq, bus.f_cnt, bus.cfg_ready);
    endtask

    task automatic test_clamp();
        send_cfg(8'd7, 23'd100, 16'd0);
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_ready_low: got %b want 0", bus.cfg_ready); end
        n_cmp++; if (bus.cfg_clamped !== 1'b1) begin n_bad++; $display("FAIL clamp_flag: got %b want 1", bus.cfg_clamped); end
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.f1_freq !== 8'd16) begin n_bad++; $display("FAIL clamp_no_commit_on_rise: got %0d want 16", bus.f1_freq); end
        bus.os_tvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (bus.cfg_applied !== 1'b0) begin n_bad++; $display("FAIL clamp_applied_early: got %b want 0", bus.cfg_applied); end
        @(posedge clk); #1;
        n_cmp++; if (bus.cfg_applied !== 1'b1) begin n_bad++; $display("FAIL clamp_applied_latency: got %b want 1", bus.cfg_applied); end
        n_cmp++; if (bus.f1_freq !== 8'd6 || bus.f_cnt !== 23'd2102)
            begin n_bad++; $display("FAIL clamp_values: got %0d/%0d want 6/2102", bus.f1_freq, bus.f_cnt); end
        n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clamp_ready_high: got %b want 1", bus.cfg_ready); end
        repeat (5) @(negedge clk);
        $display("clamp: f1=%0d f_cnt=%0d clamped=%b", bus.f1_freq, bus.f_cnt, bus.cfg_clamped);
    endtask

    task automatic test_three_line_frames();
        int fs0, ls0, le0, fe0, base;
        send_cfg(8'd8, 23'd3000, 16'd3);
        n_cmp++; if (bus.cfg_clamped !== 1'b0) begin n_bad++; $display("FAIL three_clamp_cleared: got %b want 0", bus.cfg_clamped); end
        drive_line(10, 10);
        n_cmp++; if (bus.f1_freq !== 8'd8 || bus.f_cnt !== 23'd3000)
            begin n_bad++; $display("FAIL three_cfg: got %0d/%0d want 8/3000", bus.f1_freq, bus.f_cnt); end
        @(negedge clk) bus.run = 1'b1;
        repeat (2) @(negedge clk);
        fs0 = fs_n; ls0 = ls_n; le0 = le_n; fe0 = fe_n; base = idx_log.size();
        drive_line(20, 10);
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.tvalid_gated !== 1'b1) begin n_bad++; $display("FAIL three_tvalid_gated: got %b want 1", bus.tvalid_gated); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL three_busy: got %b want 1", bus.busy); end
        repeat (10) @(negedge clk);
        bus.os_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        drive_line(20, 10);
        n_cmp++; if (fe_n - fe0 !== 1) begin n_bad++; $display("FAIL three_frame_end: got %0d want 1", fe_n - fe0); end
        n_cmp++; if (last_fe_le - le0 !== 3) begin n_bad++; $display("FAIL three_fe_on_third_fall: got %0d want 3", last_fe_le - le0); end
        n_cmp++; if (bus.frame_cnt !== 16'd1) begin n_bad++; $display("FAIL three_frame_cnt: got %0d want 1", bus.frame_cnt); end
        drive_line(20, 10);
        n_cmp++; if (fs_n - fs0 !== 2 || ls_n - ls0 !== 4)
            begin n_bad++; $display("FAIL three_starts: got fs=%0d ls=%0d want 2/4", fs_n - fs0, ls_n - ls0); end
        n_cmp++; if (idx_log.size() < base + 4 || idx_log[base] !== 16'd0 || idx_log[base+1] !== 16'd1
                     || idx_log[base+2] !== 16'd2 || idx_log[base+3] !== 16'd0)
            begin n_bad++; $display("FAIL three_line_idx: got %0d entries want 0,1,2,0", idx_log.size() - base); end
        $display("three_line: frames=%0d lines=%0d frame_cnt=%0d", fs_n - fs0, ls_n - ls0, bus.frame_cnt);
    endtask

    task automatic test_mid_frame_cfg();
        int ap0, apfe0, fe0, base;
        ap0 = ap_n; apfe0 = ap_fe_n;
        n_cmp++; if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b1)
            begin n_bad++; $display("FAIL mid_pre: got busy=%b ready=%b want 1/1", bus.busy, bus.cfg_ready); end
        send_cfg(8'd10, 23'd4000, 16'd2);
        drive_line(20, 10);
        n_cmp++; if (ap_n - ap0 !== 0 || bus.f_cnt !== 23'd3000)
            begin n_bad++; $display("FAIL mid_no_early_commit: got ap=%0d f_cnt=%0d want 0/3000", ap_n - ap0, bus.f_cnt); end
        drive_line(20, 10);
        n_cmp++; if (ap_n - ap0 !== 1 || ap_fe_n - apfe0 !== 1)
            begin n_bad++; $display("FAIL mid_commit_at_frame_end: got ap=%0d ap_fe=%0d want 1/1", ap_n - ap0, ap_fe_n - apfe0); end
        n_cmp++; if (bus.frame_cnt !== 16'd2 || bus.f1_freq !== 8'd10 || bus.f_cnt !== 23'd4000)
            begin n_bad++; $display("FAIL mid_values: got cnt=%0d f1=%0d fc=%0d want 2/10/4000",
                bus.frame_cnt, bus.f1_freq, bus.f_cnt); end
        fe0 = fe_n; base = idx_log.size();
        drive_line(20, 10);
        drive_line(20, 10);
        n_cmp++; if (fe_n - fe0 !== 1 || bus.frame_cnt !== 16'd3)
            begin n_bad++; $display("FAIL mid_two_line_frame: got fe=%0d cnt=%0d want 1/3", fe_n - fe0, bus.frame_cnt); end
        n_cmp++; if (idx_log.size() != base + 2 || idx_log[base] !== 16'd0 || idx_log[base+1] !== 16'd1)
            begin n_bad++; $display("FAIL mid_two_line_idx: got %0d entries want 0,1", idx_log.size() - base); end
        $display("mid_frame_cfg: applied=%0d frame_cnt=%0d", ap_n - ap0, bus.frame_cnt);
    endtask

    task automatic test_stop_and_arm();
        int ap0, fe0, fs0, ls0;
        @(negedge clk) bus.run = 1'b0;
        repeat (2) @(negedge clk);
        ap0 = ap_n;
        send_cfg(8'd3, 23'd7000000, 16'd3);
        drive_line(10, 10);
        n_cmp++; if (ap_n - ap0 !== 1 || bus.f1_freq !== 8'd2 || bus.f_cnt !== 23'd6250000 || bus.cfg_clamped !== 1'b1)
            begin n_bad++; $display("FAIL stop_idle_commit: got ap=%0d f1=%0d fc=%0d cl=%b want 1/2/6250000/1",
                ap_n - ap0, bus.f1_freq, bus.f_cnt, bus.cfg_clamped); end
        @(negedge clk) bus.run = 1'b1;
        fe0 = fe_n;
        drive_line(20, 10);
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        bus.run = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL stop_busy_kept: got %b want 1", bus.busy); end
        bus.os_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        drive_line(20, 10);
        n_cmp++; if (fe_n - fe0 !== 1 || bus.busy !== 1'b0 || bus.frame_cnt !== 16'd4)
            begin n_bad++; $display("FAIL stop_frame_completes: got fe=%0d busy=%b cnt=%0d want 1/0/4",
                fe_n - fe0, bus.busy, bus.frame_cnt); end
        fs0 = fs_n; ls0 = ls_n;
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        bus.run = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.tvalid_gated !== 1'b0) begin n_bad++; $display("FAIL arm_gated_partial: got %b want 0", bus.tvalid_gated); end
        bus.os_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (fs_n - fs0 !== 0 || ls_n - ls0 !== 0)
            begin n_bad++; $display("FAIL arm_partial_ignored: got fs=%0d ls=%0d want 0/0", fs_n - fs0, ls_n - ls0); end
        drive_line(20, 10);
        n_cmp++; if (fs_n - fs0 !== 1 || bus.busy !== 1'b1 || idx_log[idx_log.size()-1] !== 16'd0)
            begin n_bad++; $display("FAIL arm_next_full_line: got fs=%0d busy=%b want 1/1", fs_n - fs0, bus.busy); end
        $display("stop_and_arm: frame_cnt=%0d busy=%b", bus.frame_cnt, bus.busy);
    endtask

    task automatic test_reset_mid_frame();
        int fe0, ap0;
        send_cfg(8'd4, 23'd5000, 16'd5);
        @(negedge clk) bus.os_tvalid = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.line_idx !== 16'd1) begin n_bad++; $display("FAIL rst_mid_idx: got %0d want 1", bus.line_idx); end
        fe0 = fe_n; ap0 = ap_n;
        bus.run = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.line_idx !== 16'd0 || bus.frame_cnt !== 16'd0 || bus.tvalid_gated !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid_state: got busy=%b idx=%0d cnt=%0d tg=%b want 0/0/0/0",
                bus.busy, bus.line_idx, bus.frame_cnt, bus.tvalid_gated); end
        n_cmp++; if (bus.f1_freq !== 8'd16 || bus.f_cnt !== 23'd6250 || bus.cfg_ready !== 1'b1 || bus.cfg_clamped !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid_cfg: got f1=%0d fc=%0d rdy=%b cl=%b want 16/6250/1/0",
                bus.f1_freq, bus.f_cnt, bus.cfg_ready, bus.cfg_clamped); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus.os_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (fe_n - fe0 !== 0 || ap_n - ap0 !== 0 || bus.f1_freq !== 8'd16)
            begin n_bad++; $display("FAIL rst_mid_no_events: got fe=%0d ap=%0d f1=%0d want 0/0/16",
                fe_n - fe0, ap_n - ap0, bus.f1_freq); end
        $display("reset_mid_frame: frame_end=%0d applied=%0d", fe_n - fe0, ap_n - ap0);
    endtask

    initial begin
        bus.cfg_valid   = 1'b0;
        bus.cfg_f1_freq = 8'd0;
        bus.cfg_f_cnt   = 23'd0;
        bus.cfg_lines   = 16'd0;
        bus.run         = 1'b0;
        bus.os_tvalid   = 1'b0;
        test_reset();
        test_clamp();
        test_three_line_frames();
        test_mid_frame_cfg();
        test_stop_and_arm();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
